// File: rtl/stall_sequencer_if.sv
// stall_sequencer_if: Staller requests in, pipeline-register controls and statistics out
interface stall_sequencer_if #(
  parameter int REGBITS = 4,
  parameter int CNTBITS = 16
);
  logic               noop;
  logic               full_noop;
  logic               redirect;
  logic [REGBITS-1:0] op_E;
  logic               pc_en;
  logic               fd_en;
  logic               fd_flush;
  logic               de_bubble;
  logic               busy;
  logic [CNTBITS-1:0] stall_cycles;
  logic [CNTBITS-1:0] ctrl_events;
  modport master (
    output noop, full_noop, redirect, op_E,
    input  pc_en, fd_en, fd_flush, de_bubble, busy, stall_cycles, ctrl_events
  );
  modport slave (
    input  noop, full_noop, redirect, op_E,
    output pc_en, fd_en, fd_flush, de_bubble, busy, stall_cycles, ctrl_events
  );
endinterface

// File: rtl/stall_sequencer.sv
// stall_sequencer: turns Staller hazard requests into PC/F-D/D-E controls and keeps stall statistics
module stall_sequencer #(
  parameter int REGBITS  = 4,
  parameter int LOAD_LAT = 1,
  parameter int CTRL_LAT = 2,
  parameter int CNTBITS  = 16
) (
  input logic clk,
  input logic reset,
  stall_sequencer_if.slave bus
);
  localparam int LW = $clog2(LOAD_LAT + 1);
  localparam int CW = $clog2(CTRL_LAT + 1);
  localparam logic [REGBITS-1:0] OP_LW = REGBITS'(7);
  typedef enum logic [1:0] {IDLE, LOAD, CTRL} state_t;
  state_t             state_q, state_d;
  logic [LW-1:0]      lcnt_q, lcnt_d;
  logic [CW-1:0]      ccnt_q, ccnt_d;
  logic [CNTBITS-1:0] stall_q, stall_d;
  logic [CNTBITS-1:0] ev_q, ev_d;
  logic               pc_en, fd_en, fd_flush, de_bubble, ctrl_hit;
  // Next state, counters and per-cycle controls; reset forces the free-running defaults
  always_comb begin
    state_d   = state_q;
    lcnt_d    = lcnt_q;
    ccnt_d    = ccnt_q;
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    fd_flush  = 1'b0;
    de_bubble = 1'b0;
    ctrl_hit  = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (bus.noop) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            de_bubble = 1'b1;
            state_d   = LOAD_LAT > 1 ? LOAD : IDLE;
            lcnt_d    = LW'(LOAD_LAT > 1 ? LOAD_LAT - 2 : 0);
          end else if (bus.full_noop) begin
            pc_en    = 1'b0;
            fd_flush = 1'b1;
            ctrl_hit = 1'b1;
            state_d  = CTRL_LAT > 1 ? CTRL : IDLE;
            ccnt_d   = CW'(CTRL_LAT - 1);
          end
        end
        LOAD: begin
          pc_en     = 1'b0;
          fd_en     = 1'b0;
          de_bubble = 1'b1;
          state_d   = lcnt_q == '0 ? IDLE : LOAD;
          lcnt_d    = lcnt_q == '0 ? lcnt_q : lcnt_q - 1'b1;
        end
        CTRL: begin
          fd_flush = 1'b1;
          pc_en    = bus.redirect || ccnt_q == '0;
          state_d  = pc_en ? IDLE : CTRL;
          ccnt_d   = pc_en ? ccnt_q : ccnt_q - 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
    stall_d = (!pc_en && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    ev_d    = (ctrl_hit && bus.op_E != OP_LW && ev_q != '1) ? ev_q + 1'b1 : ev_q;
  end
  // State, sequencing counters and saturating statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lcnt_q  <= '0;
      ccnt_q  <= '0;
      stall_q <= '0;
      ev_q    <= '0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      ccnt_q  <= ccnt_d;
      stall_q <= stall_d;
      ev_q    <= ev_d;
    end
  end
  assign bus.pc_en        = pc_en;
  assign bus.fd_en        = fd_en;
  assign bus.fd_flush     = fd_flush;
  assign bus.de_bubble    = de_bubble;
  assign bus.busy         = !reset && state_q != IDLE;
  assign bus.stall_cycles = stall_q;
  assign bus.ctrl_events  = ev_q;
  // A load in E alongside a lone control request would mean noop lost its priority
  a_ctrl_not_lw: assert property (@(posedge clk) disable iff (reset)
    (state_q == IDLE && bus.full_noop && !bus.noop) |-> bus.op_E != OP_LW);
endmodule

// File: tb/tb_stall_sequencer.sv
// tb_stall_sequencer: two parameterisations against a stall-count model plus literal checkpoints
module tb_stall_sequencer;
  logic clk = 1'b0;
  logic rst, noop, full, redir;
  logic [3:0] op;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  stall_sequencer_if #(.REGBITS(4), .CNTBITS(16)) ifa ();
  stall_sequencer_if #(.REGBITS(4), .CNTBITS(4))  ifb ();
  assign ifa.noop = noop;
  assign ifa.full_noop = full;
  assign ifa.redirect = redir;
  assign ifa.op_E = op;
  assign ifb.noop = noop;
  assign ifb.full_noop = full;
  assign ifb.redirect = redir;
  assign ifb.op_E = op;
  stall_sequencer #(.REGBITS(4), .LOAD_LAT(1), .CTRL_LAT(2), .CNTBITS(16)) ua (.clk(clk), .reset(rst), .bus(ifa));
  stall_sequencer #(.REGBITS(4), .LOAD_LAT(2), .CTRL_LAT(3), .CNTBITS(4))  ub (.clk(clk), .reset(rst), .bus(ifb));
  logic        d_pc[2], d_fe[2], d_fl[2], d_bb[2], d_busy[2];
  logic [15:0] d_st[2], d_ev[2];
  assign d_pc[0] = ifa.pc_en;     assign d_pc[1] = ifb.pc_en;
  assign d_fe[0] = ifa.fd_en;     assign d_fe[1] = ifb.fd_en;
  assign d_fl[0] = ifa.fd_flush;  assign d_fl[1] = ifb.fd_flush;
  assign d_bb[0] = ifa.de_bubble; assign d_bb[1] = ifb.de_bubble;
  assign d_busy[0] = ifa.busy;    assign d_busy[1] = ifb.busy;
  assign d_st[0] = ifa.stall_cycles;       assign d_st[1] = {12'd0, ifb.stall_cycles};
  assign d_ev[0] = ifa.ctrl_events;        assign d_ev[1] = {12'd0, ifb.ctrl_events};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  int ll[2] = '{1, 2};
  int cl[2] = '{2, 3};
  int cap[2] = '{65535, 15};
  int lrem[2] = '{0, 0};
  int crem[2] = '{0, 0};
  int m_st[2] = '{0, 0};
  int m_ev[2] = '{0, 0};
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic e_pc, e_fe, e_fl, e_bb, e_busy;
      e_pc = 1; e_fe = 1; e_fl = 0; e_bb = 0;
      e_busy = lrem[i] > 0 || crem[i] > 0;
      if (rst) e_busy = 0;
      chk($sformatf("u%0d.stall_cycles", i), d_st[i], m_st[i]);
      chk($sformatf("u%0d.ctrl_events", i), d_ev[i], m_ev[i]);
      if (rst) begin
        lrem[i] = 0; crem[i] = 0;
      end else if (lrem[i] > 0) begin
        e_pc = 0; e_fe = 0; e_bb = 1; lrem[i]--;
      end else if (crem[i] > 0) begin
        e_fl = 1; e_pc = redir || crem[i] == 1;
        crem[i] = e_pc ? 0 : crem[i] - 1;
      end else if (noop) begin
        e_pc = 0; e_fe = 0; e_bb = 1; lrem[i] = ll[i] - 1;
      end else if (full) begin
        e_pc = 0; e_fl = 1; crem[i] = cl[i] > 1 ? cl[i] : 0;
        if (m_ev[i] < cap[i]) m_ev[i]++;
      end
      chk($sformatf("u%0d.pc_en", i), d_pc[i], e_pc);
      chk($sformatf("u%0d.fd_en", i), d_fe[i], e_fe);
      chk($sformatf("u%0d.fd_flush", i), d_fl[i], e_fl);
      chk($sformatf("u%0d.de_bubble", i), d_bb[i], e_bb);
      chk($sformatf("u%0d.busy", i), d_busy[i], e_busy);
      if (rst) begin
        m_st[i] = 0; m_ev[i] = 0;
      end else if (!e_pc && m_st[i] < cap[i]) m_st[i]++;
    end
  end
  task automatic step(input logic r, input logic n, input logic f, input logic d, input logic [3:0] o);
    {rst, noop, full, redir, op} = {r, n, f, d, o};
    @(posedge clk);
    #1;
  endtask
  task automatic lit(input string name, input logic [15:0] a0, input logic [15:0] e0, input logic [15:0] a1, input logic [15:0] e1);
    chk({"A.", name}, a0, e0);
    chk({"B.", name}, a1, e1);
  endtask
  initial begin
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    lit("reset_busy", 16'(ifa.busy), 0, 16'(ifb.busy), 0);
    lit("reset_stall", d_st[0], 0, d_st[1], 0);
    step(0, 1, 0, 0, 7);
    repeat (2) step(0, 0, 0, 0, 0);
    lit("load_stall", d_st[0], 1, d_st[1], 2);
    lit("load_busy", 16'(ifa.busy), 0, 16'(ifb.busy), 0);
    step(0, 0, 1, 0, 3);
    lit("ctrl_busy", 16'(ifa.busy), 1, 16'(ifb.busy), 1);
    repeat (4) step(0, 0, 0, 0, 0);
    lit("ctrl_stall", d_st[0], 3, d_st[1], 5);
    lit("ctrl_events", d_ev[0], 1, d_ev[1], 1);
    step(0, 0, 1, 0, 2);
    step(0, 0, 0, 1, 0);
    lit("redirect_busy", 16'(ifa.busy), 0, 16'(ifb.busy), 0);
    step(0, 0, 0, 1, 0);
    repeat (2) step(0, 0, 0, 0, 0);
    lit("redirect_stall", d_st[0], 4, d_st[1], 6);
    step(0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0);
    lit("prio_stall", d_st[0], 7, d_st[1], 8);
    lit("prio_events", d_ev[0], 3, d_ev[1], 2);
    repeat (20) step(0, 1, 0, 0, 0);
    lit("sat_stall", d_st[0], 27, d_st[1], 15);
    step(0, 1, 0, 0, 0);
    lit("mid_busy", 16'(ifa.busy), 0, 16'(ifb.busy), 1);
    step(1, 1, 0, 0, 0);
    lit("abort_stall", d_st[0], 0, d_st[1], 0);
    lit("abort_busy", 16'(ifa.busy), 0, 16'(ifb.busy), 0);
    repeat (2) step(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
